uart_tx_peripheral: RTL

- Memory-mapped UART transmitter on the peripheral side of the bus interconnect, alongside the LED peripheral.
- The processor writes bytes into a small TX FIFO over the same rd_en/wr_en/addr/data bus the LED peripheral uses.
- A baud-rate divider and a serialiser shift frames out on tx_o, one start bit, 8 data bits LSB-first and one stop bit.
- Exposes status and divisor registers so firmware can poll before writing.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_peripheral_sync_fifo.sv | 56 +++++
 rtl/uart_tx_peripheral.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets,
// serialiser state encoding and STATUS bit positions.
package uart_pkg;

    localparam int unsigned REG_TXDATA  = 0;
    localparam int unsigned REG_STATUS  = 1;
    localparam int unsigned REG_DIVISOR = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_CNT_MSB = 10;
    localparam int unsigned STAT_PARITY  = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Divisors below 2 cannot produce a bit period, so they run as 2.
    function automatic logic [15:0] eff_divisor(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_tx_peripheral_sync_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c    = (r_count == CNT_W'(DEPTH));
    assign o_empty_c   = (r_count == '0);
    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign w_pop       = i_pop && !o_empty_c;
    assign w_push      = i_push && (!o_full_c || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: bus decode, divisor, baud counter and
// serialiser FSM. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_peripheral
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434,
    parameter int unsigned ADDR_MSB        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned SEL_W = ADDR_MSB - 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic [SEL_W-1:0] w_sel;
    logic             w_wr_txdata;
    logic             w_wr_div;
    logic             w_rd_status;
    logic [7:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_tick;
    logic             w_pop;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_mux;
    tx_state_e        r_state;
    tx_state_e        w_state_next;
    logic [15:0]      r_div;
    logic [15:0]      r_div_active;
    logic [15:0]      r_baud_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_parity;
    logic             r_ovf;
    logic             r_tx;
    logic             r_irq;
    logic [31:0]      r_rd_data;
    logic             w_unused_bits;

    assign w_sel         = addr_i[ADDR_MSB:2];
    assign w_wr_txdata   = wr_en_i && (w_sel == SEL_W'(REG_TXDATA));
    assign w_wr_div      = wr_en_i && (w_sel == SEL_W'(REG_DIVISOR));
    assign w_rd_status   = rd_en_i && (w_sel == SEL_W'(REG_STATUS));
    assign w_tick        = (r_state != IDLE) && (r_baud_cnt == r_div_active - 16'd1);
    assign w_unused_bits = &{1'b0, addr_i[31:ADDR_MSB+1], addr_i[1:0], data_i[31:16]};

    assign data_o = r_rd_data;
    assign tx_o   = r_tx;
    assign irq_o  = r_irq;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_wr_txdata),
        .i_data      (data_i[7:0]),
        .i_pop       (w_pop),
        .o_rd_data_c (w_fifo_data),
        .o_full_c    (w_full),
        .o_empty_c   (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: if (w_tick) w_state_next = DATA;
            DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
            PARITY: if (w_tick) w_state_next = STOP;
            STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Divisor is re-latched only at bit boundaries (and freely while idle).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud_cnt   <= '0;
            r_div_active <= eff_divisor(DEFAULT_DIVISOR);
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_parity     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_parity  <= ^w_fifo_data;
                r_bit_idx <= '0;
            end else if (w_tick && (r_state == DATA)) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if ((r_state == IDLE) || w_tick) begin
                r_baud_cnt   <= '0;
                r_div_active <= eff_divisor(r_div);
            end else begin
                r_baud_cnt   <= r_baud_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_status                            = '0;
        w_status[STAT_BUSY]                 = (r_state != IDLE);
        w_status[STAT_FULL]                 = w_full;
        w_status[STAT_EMPTY]                = w_empty;
        w_status[STAT_OVF]                  = r_ovf;
        w_status[STAT_CNT_MSB:STAT_CNT_LSB] = 7'(w_count);
        w_status[STAT_PARITY]               = PARITY_EN;
        case (w_sel)
            SEL_W'(REG_STATUS):  w_rd_mux = w_status;
            SEL_W'(REG_DIVISOR): w_rd_mux = {16'h0000, r_div};
            default:             w_rd_mux = '0;
        endcase
    end

    // Reads capture pre-write contents; a STATUS read clears the sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div     <= DEFAULT_DIVISOR;
            r_rd_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= data_i[15:0];
            if (rd_en_i)  r_rd_data <= w_rd_mux;
            if (w_wr_txdata && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_rd_status)                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx  <= 1'b1;
            r_irq <= 1'b1;
        end else begin
            r_irq <= w_empty && (r_state == IDLE);
            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                PARITY:  r_tx <= r_parity;
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule
